// File: rtl/aes_dec_pipe_ctrl.sv
// Round-loop controller for the AES-128 decryption pipeline.
// Define AES_DEC_TAG_CHECK_EN to add tag_err and bubble out-of-range tags.
module aes_dec_pipe_ctrl #(
    parameter int NUM_ROUNDS   = 10,
    parameter int SHIFT_PERIOD = 5,
    parameter int DEPTH        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         aes_enable,
    input  logic         in_valid,
    input  logic [127:0] data_initial,
    output logic         in_ready,
    input  logic [131:0] data_in,
    output logic [131:0] data_out,
    output logic         shift_enable,
    output logic         pipeline_full,
    output logic [127:0] plain_out,
    output logic         out_valid,
    input  logic         out_ready
`ifdef AES_DEC_TAG_CHECK_EN
    ,
    output logic         tag_err
`endif
);

    localparam int CNT_W = (SHIFT_PERIOD > 2) ? $clog2(SHIFT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_PERIOD - 1);
    localparam logic [3:0] TAG_MAX = 4'(NUM_ROUNDS);
    localparam logic [3:0] SLOTS   = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] shift_cnt;
    logic [3:0]       pack_ct;
    logic [3:0]       tag;
    logic             stall;
    logic             slot_free;
    logic             slot_retire;
    logic             admit;
    logic             retire;
    logic             drain_done;
`ifdef AES_DEC_TAG_CHECK_EN
    logic             tag_bad;
`endif

    assign tag           = data_in[3:0];
    assign stall         = out_valid & ~out_ready;
    assign shift_enable  = (state != IDLE) & (shift_cnt == CNT_LAST) & ~stall;
    assign pipeline_full = (pack_ct == SLOTS);
    assign drain_done    = (state == DRAIN) & ~aes_enable
                         & (pack_ct == 4'd0) & ~out_valid;

    // Classify the block returning from the last loop stage by its tag.
    always_comb begin
        slot_retire = 1'b0;
        slot_free   = 1'b0;
`ifdef AES_DEC_TAG_CHECK_EN
        tag_bad     = 1'b0;
`endif
        if (tag == 4'd1) begin
            slot_retire = 1'b1;
            slot_free   = 1'b1;
        end else if (tag == 4'd0) begin
            slot_free = 1'b1;
`ifdef AES_DEC_TAG_CHECK_EN
        end else if (tag > TAG_MAX) begin
            tag_bad   = 1'b1;
            slot_free = 1'b1;
`endif
        end
    end

    assign retire   = shift_enable & slot_retire;
    assign admit    = shift_enable & slot_free & (state == RUN) & in_valid
                    & ((pack_ct < SLOTS) | slot_retire);
    assign in_ready = admit;

    // Choose what enters the first loop stage: new block, recirculation or bubble.
    always_comb begin
        data_out = '0;
        if (admit) begin
            data_out = {data_initial, TAG_MAX};
        end else if (shift_enable & ~slot_free) begin
            data_out = {data_in[131:4], tag - 4'd1};
        end
    end

    // Mode FSM, shift pacing, in-flight count and retired-block register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pack_ct   <= 4'd0;
            plain_out <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (aes_enable) state <= RUN;
                RUN:     if (!aes_enable) state <= DRAIN;
                DRAIN: begin
                    if (aes_enable) state <= RUN;
                    else if (drain_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (state == IDLE || drain_done) begin
                shift_cnt <= '0;
            end else if (!stall) begin
                shift_cnt <= (shift_cnt == CNT_LAST) ? '0 : shift_cnt + 1'b1;
            end

            if (admit && !retire) begin
                pack_ct <= pack_ct + 4'd1;
            end else if (retire && !admit && pack_ct != 4'd0) begin
                pack_ct <= pack_ct - 4'd1;
            end

            if (retire) begin
                out_valid <= 1'b1;
                plain_out <= data_in[131:4];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AES_DEC_TAG_CHECK_EN
    // Sticky flag for a corrupted round tag seen on a shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (shift_enable && tag_bad) begin
            tag_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_dec_pipe_ctrl.sv
// Testbench for aes_dec_pipe_ctrl: decode table, directed sequences,
// and randomized traffic against a block-lifetime reference model.
module tb_aes_dec_pipe_ctrl;

    localparam int NUM_ROUNDS   = 10;
    localparam int SHIFT_PERIOD = 5;
    localparam int DEPTH        = 4;
    localparam int LAT_SHIFTS   = NUM_ROUNDS * DEPTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         aes_enable;
    logic         in_valid;
    logic [127:0] data_initial;
    logic         in_ready;
    logic [131:0] data_in;
    logic [131:0] data_out;
    logic         shift_enable;
    logic         pipeline_full;
    logic [127:0] plain_out;
    logic         out_valid;
    logic         out_ready;
`ifdef AES_DEC_TAG_CHECK_EN
    logic         tag_err;
`endif

    logic         inject_en;
    logic [131:0] inject_val;
    logic [131:0] loop_q [DEPTH];

    int tests  = 0;
    int failed = 0;

    aes_dec_pipe_ctrl #(
        .NUM_ROUNDS  (NUM_ROUNDS),
        .SHIFT_PERIOD(SHIFT_PERIOD),
        .DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .aes_enable   (aes_enable),
        .in_valid     (in_valid),
        .data_initial (data_initial),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .data_out     (data_out),
        .shift_enable (shift_enable),
        .pipeline_full(pipeline_full),
        .plain_out    (plain_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef AES_DEC_TAG_CHECK_EN
        ,
        .tag_err      (tag_err)
`endif
    );

    always #5 clk = ~clk;

    // Loop stages: a DEPTH-slot shift register advanced by shift_enable.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) loop_q[i] <= '0;
        end else if (shift_enable) begin
            loop_q[0] <= data_out;
            for (int i = 1; i < DEPTH; i++) loop_q[i] <= loop_q[i-1];
        end
    end

    assign data_in = inject_en ? inject_val : loop_q[DEPTH-1];

    // Reference model: each admitted block is known by the shift number
    // it entered on; it comes back every DEPTH shifts and retires after
    // NUM_ROUNDS*DEPTH shifts.
    typedef struct {
        int           k;
        logic [127:0] d;
    } blk_t;

    blk_t         live[$];
    int           shift_no;
    logic         exp_ov;
    logic [127:0] exp_plain;
    logic         run_exp;
    bit           model_on;

    logic         last_shift;
    logic         last_ir;
    logic         last_ov;
    logic [131:0] last_do;

    task automatic chk(input string name, input logic [131:0] act,
                       input logic [131:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        logic [131:0] exp_do;
        logic         exp_ir;
        logic [127:0] rd;
        bit           ret;
        int           n;
        int           idx;
        blk_t         nb;
        if (rst) begin
            live.delete();
            shift_no  = 0;
            exp_ov    = 1'b0;
            exp_plain = '0;
            run_exp   = 1'b0;
            return;
        end
        chk("out_valid", out_valid, exp_ov);
        chk("plain_out", plain_out, exp_plain);
        chk("pipeline_full", pipeline_full, live.size() == DEPTH);
        if (exp_ov && !out_ready) chk("stall_no_shift", shift_enable, 0);
        ret    = 0;
        exp_ir = 1'b0;
        exp_do = '0;
        rd     = '0;
        if (shift_enable) begin
            n   = shift_no + 1;
            idx = -1;
            foreach (live[i]) if ((n - live[i].k) % DEPTH == 0) idx = i;
            if (idx >= 0 && (n - live[idx].k) == LAT_SHIFTS) begin
                ret = 1;
                rd  = live[idx].d;
                live.delete(idx);
                idx = -1;
            end
            if (idx >= 0) begin
                exp_do = {live[idx].d,
                          4'(NUM_ROUNDS - (n - live[idx].k) / DEPTH)};
            end else if (run_exp && in_valid) begin
                exp_ir = 1'b1;
                exp_do = {data_initial, 4'(NUM_ROUNDS)};
                nb.k   = n;
                nb.d   = data_initial;
                live.push_back(nb);
            end
            chk("data_out", data_out, exp_do);
            shift_no = n;
        end
        chk("in_ready", in_ready, exp_ir);
        if (ret) begin
            exp_ov    = 1'b1;
            exp_plain = rd;
        end else if (exp_ov && out_ready) begin
            exp_ov = 1'b0;
        end
        run_exp = aes_enable;
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        #1;
        last_shift = shift_enable;
        last_ir    = in_ready;
        last_ov    = out_valid;
        last_do    = data_out;
        if (model_on) model_cycle();
        @(negedge clk);
    endtask

    task automatic wait_shift(input int limit, output int n);
        n = 0;
        forever begin
            cycle();
            if (last_shift) break;
            n++;
            if (n >= limit) begin
                tests++;
                failed++;
                $display("FAIL wait_shift: no shift within %0d clks", limit);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        aes_enable = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        inject_en  = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag_name);
        chk({tag_name, "_in_ready"}, in_ready, 0);
        chk({tag_name, "_shift_enable"}, shift_enable, 0);
        chk({tag_name, "_pipeline_full"}, pipeline_full, 0);
        chk({tag_name, "_out_valid"}, out_valid, 0);
        chk({tag_name, "_plain_out"}, plain_out, 0);
        chk({tag_name, "_data_out"}, data_out, 0);
    endtask

    typedef struct {
        logic [3:0] tag;
        logic       iv;
        logic       exp_ir;
        logic [1:0] kind;
        logic [3:0] exp_tag;
        logic       exp_ret;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int           n;
        int           lat;
        int           shifts;
        int           guard;
        int           nadm;
        logic [127:0] blk;
        logic [127:0] c_fix;
        logic [131:0] exp_do;
        logic         adm [0:63];

        // kind: 0 bubble, 1 new block, 2 recirculated injected block
        vecs[0] = '{4'd0,  1'b0, 1'b0, 2'd0, 4'd0,  1'b0};
        vecs[1] = '{4'd0,  1'b1, 1'b1, 2'd1, 4'd10, 1'b0};
        vecs[2] = '{4'd5,  1'b1, 1'b0, 2'd2, 4'd4,  1'b0};
        vecs[3] = '{4'd10, 1'b1, 1'b0, 2'd2, 4'd9,  1'b0};
        vecs[4] = '{4'd2,  1'b0, 1'b0, 2'd2, 4'd1,  1'b0};
        vecs[5] = '{4'd1,  1'b0, 1'b0, 2'd0, 4'd0,  1'b1};
        vecs[6] = '{4'd1,  1'b1, 1'b1, 2'd1, 4'd10, 1'b1};
`ifdef AES_DEC_TAG_CHECK_EN
        vecs[7] = '{4'd13, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0};
`else
        vecs[7] = '{4'd13, 1'b0, 1'b0, 2'd2, 4'd12, 1'b0};
`endif
        vecs[8] = '{4'd0,  1'b1, 1'b1, 2'd1, 4'd10, 1'b0};
`ifdef AES_DEC_TAG_CHECK_EN
        vecs[9] = '{4'd15, 1'b1, 1'b1, 2'd1, 4'd10, 1'b0};
`else
        vecs[9] = '{4'd15, 1'b1, 1'b0, 2'd2, 4'd14, 1'b0};
`endif

        rst          = 1'b1;
        aes_enable   = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        data_initial = '0;
        inject_en    = 1'b0;
        inject_val   = '0;
        model_on     = 1'b1;
        live.delete();
        shift_no     = 0;
        exp_ov       = 1'b0;
        exp_plain    = '0;
        run_exp      = 1'b0;
        @(negedge clk);

        // Single block, first-shift timing, latency, then backpressure.
        do_reset();
        check_zero("reset");
        c_fix        = {16{8'hA5}};
        data_initial = c_fix;
        aes_enable   = 1'b1;
        in_valid     = 1'b1;
        wait_shift(20, n);
        chk("first_shift_clks", n, 5);
        chk("admit_in_ready", last_ir, 1);
        chk("admit_data_out", last_do, {c_fix, 4'd10});
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lat       = 0;
        shifts    = 0;
        cycle();
        if (last_shift) shifts++;
        while (!last_ov && lat < 400) begin
            cycle();
            lat++;
            if (last_shift && !last_ov) shifts++;
        end
        chk("latency_clks", lat, 5 * LAT_SHIFTS);
        chk("latency_shifts", shifts, LAT_SHIFTS);
        chk("single_plain", plain_out, c_fix);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stall_hold", last_shift, 0);
        end
        out_ready = 1'b1;
        wait_shift(20, n);
        chk("resume_clks", n, SHIFT_PERIOD - 1);

        // Fill with back-to-back offers, retire+admit, then mid-run reset.
        do_reset();
        aes_enable = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 64; i++) adm[i] = 1'b0;
        shifts = 0;
        guard  = 0;
        while (shifts < 50 && guard < 1000) begin
            data_initial = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            guard++;
            if (last_shift) begin
                shifts++;
                adm[shifts] = last_ir;
                if (shifts == DEPTH) chk("full_after_fill", pipeline_full, 1);
            end
        end
        chk("fill_admit_1_4", {adm[1], adm[2], adm[3], adm[4]}, 4'b1111);
        nadm = 0;
        for (int i = 5; i <= LAT_SHIFTS; i++) nadm += int'(adm[i]);
        chk("fill_no_admit_5_40", nadm, 0);
        chk("retire_admit_41", adm[LAT_SHIFTS + 1], 1);
        chk("full_after_41", pipeline_full, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_zero("midrun_reset");

        // Drain with two blocks in flight, then idle hold and restart.
        do_reset();
        aes_enable = 1'b1;
        in_valid   = 1'b1;
        nadm       = 0;
        guard      = 0;
        while (nadm < 2 && guard < 100) begin
            data_initial = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            guard++;
            if (last_shift && last_ir) nadm++;
        end
        aes_enable = 1'b0;
        guard      = 0;
        while ((live.size() != 0 || exp_ov) && guard < 600) begin
            cycle();
            guard++;
        end
        chk("drain_completes", guard < 600, 1);
        for (int i = 0; i < 3 * SHIFT_PERIOD; i++) begin
            cycle();
            chk("idle_no_shift", last_shift, 0);
        end
        aes_enable = 1'b1;
        in_valid   = 1'b0;
        wait_shift(20, n);
        chk("restart_clks", n, 5);

        // Decode table with tags forced on data_in.
        do_reset();
        model_on     = 1'b0;
        aes_enable   = 1'b1;
        out_ready    = 1'b1;
        c_fix        = {4{32'h13579BDF}};
        data_initial = c_fix;
        for (int i = 0; i < 10; i++) begin
            blk        = {4{32'hC0DE0000 | 32'(i)}};
            inject_val = {blk, vecs[i].tag};
            inject_en  = 1'b1;
            in_valid   = vecs[i].iv;
            wait_shift(3 * SHIFT_PERIOD, n);
            case (vecs[i].kind)
                2'd1:    exp_do = {c_fix, vecs[i].exp_tag};
                2'd2:    exp_do = {blk, vecs[i].exp_tag};
                default: exp_do = '0;
            endcase
            chk($sformatf("vec%0d_in_ready", i), last_ir, vecs[i].exp_ir);
            chk($sformatf("vec%0d_data_out", i), last_do, exp_do);
            if (vecs[i].exp_ret) begin
                chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
                chk($sformatf("vec%0d_plain", i), plain_out, blk);
            end
            in_valid = 1'b0;
        end
`ifdef AES_DEC_TAG_CHECK_EN
        chk("tag_err_sticky", tag_err, 1);
`endif
        inject_en = 1'b0;

        // Randomized traffic against the reference model.
        model_on = 1'b1;
        do_reset();
        aes_enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (aes_enable) aes_enable = ($urandom_range(0, 99) >= 1);
            else            aes_enable = ($urandom_range(0, 99) < 5);
            in_valid     = ($urandom_range(0, 99) < 60);
            out_ready    = ($urandom_range(0, 99) < 75);
            data_initial = {$urandom, $urandom, $urandom, $urandom};
            rst          = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
